// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer: periodic / one-shot interval timer.
//
// The interval TIMER_PERIOD_ns is converted into N = TIMER_PERIOD_ns /
// CLK_PERIOD_ns clock cycles. While start is held high the timer runs freely
// and emits a one-cycle done tick every N cycles. If start is low when the
// terminal count is reached, the current interval completes with a single
// tick and the timer returns to idle.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   sync_resetn  synchronous active-low clear (same effect as reset)
//   enable       count enable; low freezes state/count and forces done low
//   start        level-sensitive run request
//   done         registered one-cycle tick per completed interval
// ---------------------------------------------------------------------------
module timer #(
  parameter int CLK_PERIOD_ns   = 20,
  parameter int TIMER_PERIOD_ns = 100
) (
  input  logic clk,
  input  logic resetn,
  input  logic sync_resetn,
  input  logic enable,
  input  logic start,
  output logic done
);

  localparam int N  = TIMER_PERIOD_ns / CLK_PERIOD_ns;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // The interval must be a whole, non-zero number of clock cycles.
  if (CLK_PERIOD_ns <= 0 || N < 1 || (N * CLK_PERIOD_ns) != TIMER_PERIOD_ns) begin : g_bad_period
    $error("timer: TIMER_PERIOD_ns must be a positive integer multiple of CLK_PERIOD_ns");
  end

  localparam logic [CW-1:0] RELOAD = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (!sync_resetn) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (!enable) begin
      // Frozen: state and count hold, so the interval stretches.
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            cnt   <= RELOAD;
          end
        end
        default: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            done <= 1'b0;
          end else begin
            done <= 1'b1;
            // Terminal count: reload with no gap if still requested,
            // otherwise this was a one-shot.
            if (start) cnt   <= RELOAD;
            else       state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer: directed checks of timer with N = 5 (table-driven) and N = 1,
// plus hand-written asynchronous reset sequences.
// ---------------------------------------------------------------------------
module tb_timer;

  logic clk;
  logic resetn, sync_resetn, enable, start;
  logic done;
  logic resetn1, sync_resetn1, enable1, start1;
  logic done1;

  timer #(.CLK_PERIOD_ns(20), .TIMER_PERIOD_ns(100)) dut (
    .clk(clk), .resetn(resetn), .sync_resetn(sync_resetn),
    .enable(enable), .start(start), .done(done)
  );

  timer #(.CLK_PERIOD_ns(20), .TIMER_PERIOD_ns(20)) dut1 (
    .clk(clk), .resetn(resetn1), .sync_resetn(sync_resetn1),
    .enable(enable1), .start(start1), .done(done1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic  sync_resetn;
    logic  enable;
    logic  start;
    logic  done_exp;
    string tag;
  } vec_t;

  vec_t tbl[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: done=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Push `count` identical cycles: inputs for an edge and done expected after it.
  task automatic vec(input logic s, input logic e, input logic st,
                     input logic d, input int count, input string tag);
    vec_t v;
    v.sync_resetn = s; v.enable = e; v.start = st; v.done_exp = d; v.tag = tag;
    for (int i = 0; i < count; i++) tbl.push_back(v);
  endtask

  task automatic edge_chk(input string nm, input logic exp);
    @(posedge clk); #1;
    chk(nm, done, exp);
  endtask

  initial begin
    resetn = 1'b0; sync_resetn = 1'b1; enable = 1'b1; start = 1'b0;
    resetn1 = 1'b0; sync_resetn1 = 1'b1; enable1 = 1'b1; start1 = 1'b0;

    // Free-run: ticks at E0+5, +10, +15, then one-shot finish at +20.
    vec(1,1,1,0,5,"free_run");
    for (int k = 0; k < 3; k++) begin
      vec(1,1,1,1,1,"free_run_tick");
      vec(1,1,1,0,4,"free_run");
    end
    vec(1,1,0,1,1,"free_run_last");
    vec(1,1,0,0,3,"free_run_idle");
    // One-shot: single pulse at E0+5, then silence for 20 cycles.
    vec(1,1,1,0,1,"oneshot");
    vec(1,1,0,0,4,"oneshot");
    vec(1,1,0,1,1,"oneshot_tick");
    vec(1,1,0,0,20,"oneshot_quiet");
    // Enable dropped for 3 cycles at cnt = 2: tick at E0+8.
    vec(1,1,1,0,1,"en_freeze");
    vec(1,1,0,0,2,"en_freeze");
    vec(1,0,0,0,3,"en_freeze_off");
    vec(1,1,0,0,2,"en_freeze");
    vec(1,1,0,1,1,"en_freeze_tick");
    vec(1,1,0,0,3,"en_freeze");
    // Enable low on the terminal-count edge: tick deferred one edge.
    vec(1,1,1,0,1,"en_term");
    vec(1,1,0,0,4,"en_term");
    vec(1,0,0,0,1,"en_term_off");
    vec(1,1,0,1,1,"en_term_tick");
    vec(1,1,0,0,2,"en_term");
    // Sync clear at cnt = 1 with start held: restart, tick 5 cycles later.
    vec(1,1,1,0,4,"sclr_mid");
    vec(0,1,1,0,1,"sclr_mid_clr");
    vec(1,1,1,0,5,"sclr_mid_restart");
    vec(1,1,1,1,1,"sclr_mid_tick");
    vec(1,1,0,0,4,"sclr_mid");
    vec(1,1,0,1,1,"sclr_mid_tick2");
    vec(1,1,0,0,2,"sclr_mid");
    // Sync clear on the terminal-count edge: no pulse at all.
    vec(1,1,1,0,1,"sclr_term");
    vec(1,1,0,0,4,"sclr_term");
    vec(0,1,0,0,1,"sclr_term_clr");
    vec(1,1,0,0,6,"sclr_term_quiet");

    // Reset state.
    @(posedge clk); #1;
    chk("reset_done", done, 1'b0);
    chk("reset_done_n1", done1, 1'b0);
    @(negedge clk);
    resetn = 1'b1; resetn1 = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      sync_resetn = tbl[i].sync_resetn;
      enable      = tbl[i].enable;
      start       = tbl[i].start;
      @(posedge clk); #1;
      chk(tbl[i].tag, done, tbl[i].done_exp);
    end

    // Asynchronous reset right after a tick: done must drop immediately.
    @(negedge clk);
    sync_resetn = 1'b1; enable = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) edge_chk("areset_pre", 1'b0);
    edge_chk("areset_pre_tick", 1'b1);
    #3 resetn = 1'b0;
    #1 chk("areset_immediate", done, 1'b0);
    edge_chk("areset_held", 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) edge_chk("areset_restart", 1'b0);
    edge_chk("areset_restart_tick", 1'b1);
    // Reset mid-count (cnt = 2): progress is discarded, full interval follows.
    edge_chk("areset_mid", 1'b0);
    edge_chk("areset_mid", 1'b0);
    #4 resetn = 1'b0;
    #4 resetn = 1'b1;
    for (int i = 0; i < 5; i++) edge_chk("areset_mid_restart", 1'b0);
    edge_chk("areset_mid_tick", 1'b1);
    @(negedge clk);
    start = 1'b0;

    // N = 1: done high every cycle from one cycle after start.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    chk("n1_start_edge", done1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("n1_free_run", done1, 1'b1);
    end
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_last_tick", done1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("n1_idle", done1, 1'b0);
    end
    // N = 1 one-shot: single pulse.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    chk("n1_oneshot_start", done1, 1'b0);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_oneshot_tick", done1, 1'b1);
    @(posedge clk); #1;
    chk("n1_oneshot_after", done1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Hard stop in case something above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

endmodule
